// File: rtl/console_out_pkg.sv
// Shared constants for the console output peripheral: register offsets, STATUS layout
// and drain-FSM states.
package console_out_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_STATS  = 2'd2;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_MSB   = 15;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } drain_state_t;

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO, head visible combinationally; zero-latency pop, push ignored by caller when full.
// Pointers wrap naturally; count is one bit wider than the pointers so full and empty are distinct.
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/console_out.sv
// picorv32-bus char output: DATA writes buffer in a FIFO and drain as toggle-signalled bytes;
// mem_ready 1 clk after hit, withheld on full-FIFO DATA writes. CONSOLE_OUT_STATS_EN adds a byte counter.
module console_out
  import console_out_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  out_dat,
  output logic        out_ctl
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int HCW = $clog2(HOLD_CYCLES);

  logic          w_hit;
  logic [1:0]    w_ofs;
  logic          w_is_wr;
  logic          w_data_wr;
  logic          w_stall;
  logic          w_done;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [31:0]   w_rd_val;
  logic [31:0]   w_stats_rd;
  logic          w_unused;

  logic          r_ready;
  logic [31:0]   r_rdata;
  logic [7:0]    r_out_dat;
  logic          r_out_ctl;
  logic [HCW-1:0] r_hold;
  drain_state_t  r_state;
  drain_state_t  w_state_nxt;

  // The !r_ready term forces one idle cycle between accesses so a held mem_valid is not serviced twice.
  assign w_hit     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !r_ready;
  assign w_ofs     = mem_addr[3:2];
  assign w_is_wr   = |mem_wstrb;
  assign w_data_wr = w_hit && (w_ofs == OFS_DATA) && mem_wstrb[0];
  assign w_stall   = w_data_wr && w_full;
  assign w_done    = w_hit && !w_stall;
  assign w_push    = w_data_wr && !w_full;
  assign w_unused  = ^{mem_addr[1:0], mem_wdata[31:8]};

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (mem_wdata[7:0]),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  always_comb begin
    w_rd_val = '0;
    if (!w_is_wr) begin
      case (w_ofs)
        OFS_STATUS: begin
          w_rd_val[STAT_FULL_BIT]              = w_full;
          w_rd_val[STAT_EMPTY_BIT]             = w_empty;
          w_rd_val[STAT_CNT_MSB:STAT_CNT_LSB]  = 8'(w_count);
        end
        OFS_STATS: w_rd_val = w_stats_rd;
        default:   w_rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_done;
      r_rdata <= w_done ? w_rd_val : '0;
    end
  end

`ifdef CONSOLE_OUT_STATS_EN
  logic [31:0] r_stats;
  logic        w_stats_clr;

  assign w_stats_clr = w_done && w_is_wr && (w_ofs == OFS_STATS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stats <= '0;
    end else if (w_stats_clr) begin
      r_stats <= {31'b0, w_pop};
    end else if (w_pop) begin
      r_stats <= r_stats + 32'd1;
    end
  end

  assign w_stats_rd = r_stats;
`else
  assign w_stats_rd = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = HOLD;
      HOLD:    if (r_hold == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pop = (r_state == IDLE) && !w_empty;
  end

  // out_dat only moves on the same edge as the out_ctl toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_dat <= '0;
      r_out_ctl <= 1'b0;
      r_hold    <= '0;
    end else if (w_pop) begin
      r_out_dat <= w_head;
      r_out_ctl <= ~r_out_ctl;
      r_hold    <= HCW'(HOLD_CYCLES - 1);
    end else if ((r_state == HOLD) && (r_hold != '0)) begin
      r_hold    <= r_hold - 1'b1;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign out_dat   = r_out_dat;
  assign out_ctl   = r_out_ctl;

endmodule

// File: tb/tb_console_out.sv
// Directed bench for console_out: bus timing, drain pacing and order, full-FIFO stall,
// STATUS, window decode, mid-run reset, and the optional byte counter.
module tb_console_out;

  localparam logic [31:0] A_DATA   = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_STATS  = 32'h1000_0008;
  localparam logic [31:0] A_RSVD   = 32'h1000_000C;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  out_dat;
  logic        out_ctl;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic       mon_mute = 1'b1;
  logic       prev_ctl = 1'b0;
  logic [7:0] q_dat[$];
  int         q_cyc[$];

  console_out dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .out_dat   (out_dat),
    .out_ctl   (out_ctl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Consumer model: every out_ctl edge delivers the byte on out_dat.
  always @(negedge clk) begin
    if (!mon_mute && (out_ctl !== prev_ctl)) begin
      q_dat.push_back(out_dat);
      q_cyc.push_back(cyc);
    end
    prev_ctl = out_ctl;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where mem_ready is seen high.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int waited);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    waited    = 0;
    rd        = '0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        waited = i;
        rd     = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
    if (waited == 0) begin
      checks++;
      errors++;
      $error("FAIL bus_timeout: observed no mem_ready for addr 0x%08h, expected one within 50 cycles", a);
    end
  endtask

  task automatic wait_toggles(input int n, input int budget);
    int k = 0;
    while ((q_dat.size() < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    checks++;
    assert (q_dat.size() >= n) else begin
      errors++;
      $error("FAIL toggle_wait: observed %0d toggles expected %0d", q_dat.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  hello[5];
    int w;
    int base;
    int n0;
    int hits;
    int stalls;
    int wt[14];

    hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;

    repeat (3) @(negedge clk);
    check("rst_out_dat", 32'(out_dat), 32'h0);
    check("rst_out_ctl", 32'(out_ctl), 32'h0);
    check("rst_ready",   32'(mem_ready), 32'h0);
    check("rst_rdata",   mem_rdata, 32'h0);
    rst      = 1'b0;
    mon_mute = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte into an empty FIFO.
    bus(A_DATA, 32'h48, 4'b0001, rd, w);
    check("first_ready_latency", w, 1);
    check("ctl_at_ready", 32'(out_ctl), 32'h0);
    @(negedge clk);
    check("ctl_after_ready", 32'(out_ctl), 32'h1);
    check("dat_after_ready", 32'(out_dat), 32'h48);

    // "Hello" back-to-back: max-rate drain.
    repeat (10) @(negedge clk);
    base = q_dat.size();
    for (int i = 0; i < 5; i++) begin
      bus(A_DATA, 32'(hello[i]), 4'b0001, rd, w);
      if (i > 0) check("hello_wr_spacing", w, 2);
    end
    wait_toggles(base + 5, 100);
    for (int i = 0; i < 5; i++) check("hello_byte", 32'(q_dat[base+i]), 32'(hello[i]));
    for (int i = 1; i < 5; i++) check("hello_gap", q_cyc[base+i] - q_cyc[base+i-1], 5);

    // 14 writes at full rate: FIFO reaches 8 entries and the 14th write stalls one cycle.
    repeat (10) @(negedge clk);
    base   = q_dat.size();
    stalls = 0;
    for (int i = 0; i < 14; i++) begin
      bus(A_DATA, 32'(8'h41 + i), 4'b0001, rd, w);
      wt[i] = w;
      if (w > 2) stalls++;
    end
    bus(A_STATUS, 32'h0, 4'b0000, rd, w);
    check("status_full", rd, 32'h0000_0801);
    check("fill_first_wait", wt[0], 1);
    check("fill_13th_wait", wt[12], 2);
    check("fill_14th_wait", wt[13], 3);
    check("fill_stall_count", stalls, 1);
    wait_toggles(base + 14, 200);
    for (int i = 0; i < 14; i++) check("fill_order", 32'(q_dat[base+i]), 32'(8'h41 + i));

    // Idle register reads and ignored writes.
    repeat (10) @(negedge clk);
    bus(A_STATUS, 32'h0, 4'b0000, rd, w);
    check("status_drained", rd, 32'h0000_0002);
    bus(A_DATA, 32'h0, 4'b0000, rd, w);
    check("data_read_zero", rd, 32'h0);
    bus(A_RSVD, 32'h0, 4'b0000, rd, w);
    check("rsvd_read_zero", rd, 32'h0);
    n0 = q_dat.size();
    bus(A_RSVD, 32'h55, 4'b1111, rd, w);
    bus(A_DATA, 32'h77, 4'b0010, rd, w);
    check("nostrb_write_completes", w, 2);
    repeat (12) @(negedge clk);
    check("nostrb_no_push", q_dat.size(), n0);
    bus(A_STATUS, 32'h0, 4'b0000, rd, w);
    check("status_after_ignored", rd, 32'h0000_0002);

    mem_valid = 1'b1;
    mem_addr  = 32'h1000_0010;
    mem_wstrb = 4'b0000;
    hits      = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready) hits++;
    end
    mem_valid = 1'b0;
    check("out_of_window_no_ready", hits, 0);
    check("out_of_window_rdata", mem_rdata, 32'h0);

    // Reset with 4 bytes still buffered.
    repeat (4) @(negedge clk);
    base = q_dat.size();
    for (int i = 0; i < 7; i++) bus(A_DATA, 32'(8'h61 + i), 4'b0001, rd, w);
    check("pre_rst_toggles", q_dat.size() - base, 3);
    check("pre_rst_ctl", 32'(out_ctl), 32'h1);
    mon_mute = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_dat", 32'(out_dat), 32'h0);
    check("midrst_out_ctl", 32'(out_ctl), 32'h0);
    check("midrst_ready",   32'(mem_ready), 32'h0);
    @(negedge clk);
    mon_mute = 1'b0;
    n0 = q_dat.size();
    repeat (30) @(negedge clk);
    check("midrst_no_toggles", q_dat.size(), n0);
    check("midrst_ctl_quiet", 32'(out_ctl), 32'h0);
    bus(A_STATUS, 32'h0, 4'b0000, rd, w);
    check("midrst_status", rd, 32'h0000_0002);

`ifdef CONSOLE_OUT_STATS_EN
    for (int i = 0; i < 3; i++) bus(A_DATA, 32'(8'h30 + i), 4'b0001, rd, w);
    repeat (30) @(negedge clk);
    bus(A_STATS, 32'h0, 4'b0000, rd, w);
    check("stats_three", rd, 32'd3);
    bus(A_STATS, 32'hDEAD_BEEF, 4'b1111, rd, w);
    bus(A_STATS, 32'h0, 4'b0000, rd, w);
    check("stats_cleared", rd, 32'd0);
`else
    bus(A_STATS, 32'h0, 4'b0000, rd, w);
    check("stats_absent", rd, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
